// File: rtl/button_conditioner.sv
// Debounces the run and direction push-buttons into clean toggle levels and one-cycle press pulses.
// Optional build macro BTN_ACTIVE_LOW_EN selects active-low board buttons.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_run,
  input  logic btn_dir,
  output logic enable,
  output logic up_down,
  output logic run_pulse,
  output logic dir_pulse
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  // Bit 0 is the run channel (enable resets to 0), bit 1 the dir channel (up_down resets to 1).
  localparam logic [1:0] LEVEL_RST = 2'b10;

`ifdef BTN_ACTIVE_LOW_EN
  // Synchronizer flops keep the pin level, so they reset to the released (high) pin level.
  localparam logic SYNC_RST = 1'b1;
`else
  localparam logic SYNC_RST = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } state_t;

  logic [1:0] raw_vec;
  logic [1:0] pulse_vec;
  logic [1:0] level_vec;

  assign raw_vec = {btn_dir, btn_run};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_chan
      logic             sync1_reg;
      logic             sync2_reg;
      logic             s;
      state_t           state_reg;
      logic [CNT_W-1:0] cnt_reg;
      logic             pulse_reg;
      logic             level_reg;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          sync1_reg <= SYNC_RST;
          sync2_reg <= SYNC_RST;
        end else begin
          sync1_reg <= raw_vec[gi];
          sync2_reg <= sync1_reg;
        end
      end

`ifdef BTN_ACTIVE_LOW_EN
      assign s = ~sync2_reg;
`else
      assign s = sync2_reg;
`endif

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          state_reg <= IDLE;
          cnt_reg   <= '0;
          pulse_reg <= 1'b0;
          level_reg <= LEVEL_RST[gi];
        end else begin
          pulse_reg <= 1'b0;
          case (state_reg)
            IDLE: begin
              if (s) begin
                state_reg <= PRESS_WAIT;
                cnt_reg   <= '0;
              end
            end
            PRESS_WAIT: begin
              if (!s) begin
                state_reg <= IDLE;
              end else if (cnt_reg == CNT_MAX) begin
                state_reg <= PRESSED;
                pulse_reg <= 1'b1;
                level_reg <= ~level_reg;
              end else begin
                cnt_reg <= cnt_reg + 1'b1;
              end
            end
            PRESSED: begin
              if (!s) begin
                state_reg <= RELEASE_WAIT;
                cnt_reg   <= '0;
              end
            end
            RELEASE_WAIT: begin
              if (s) begin
                state_reg <= PRESSED;
              end else if (cnt_reg == CNT_MAX) begin
                state_reg <= IDLE;
              end else begin
                cnt_reg <= cnt_reg + 1'b1;
              end
            end
            default: state_reg <= IDLE;
          endcase
        end
      end

      assign pulse_vec[gi] = pulse_reg;
      assign level_vec[gi] = level_reg;
    end
  endgenerate

  assign run_pulse = pulse_vec[0];
  assign dir_pulse = pulse_vec[1];
  assign enable    = level_vec[0];
  assign up_down   = level_vec[1];

endmodule

// File: tb/tb_button_conditioner.sv
// Randomized and directed bench for button_conditioner against a run-length debounce model.
module tb_button_conditioner;

  localparam int D = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic btn_run = 1'b0;
  logic btn_dir = 1'b0;
  logic enable, up_down, run_pulse, dir_pulse;

  int vec_count = 0;
  int err_count = 0;

  // Model: a press is accepted after D+1 consecutive synchronized samples of 1 while
  // released, a release after D+1 consecutive samples of 0 while pressed.
  bit h1 [2];
  bit h2 [2];
  bit pressed [2];
  int run_len [2];
  bit exp_pulse [2];
  bit exp_level [2];
  int pulse_total [2];

  button_conditioner #(.DEBOUNCE_CYCLES(D)) dut (
    .clk(clk),
    .rst(rst),
    .btn_run(btn_run),
    .btn_dir(btn_dir),
    .enable(enable),
    .up_down(up_down),
    .run_pulse(run_pulse),
    .dir_pulse(dir_pulse)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic got, input logic exp);
    vec_count++;
    if (got !== exp) begin
      err_count++;
      $display("FAIL %s got=%0b expected=%0b at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      h1[c] = 1'b0;
      h2[c] = 1'b0;
      pressed[c] = 1'b0;
      run_len[c] = 0;
      exp_pulse[c] = 1'b0;
    end
    exp_level[0] = 1'b0;
    exp_level[1] = 1'b1;
  endtask

  task automatic model_edge(input bit r, input bit d);
    bit raw [2];
    bit s;
    raw[0] = r;
    raw[1] = d;
    for (int c = 0; c < 2; c++) begin
      s = h2[c];
      exp_pulse[c] = 1'b0;
      if (s == !pressed[c]) run_len[c]++;
      else run_len[c] = 0;
      if (run_len[c] == D + 1) begin
        run_len[c] = 0;
        pressed[c] = !pressed[c];
        if (pressed[c]) begin
          exp_pulse[c] = 1'b1;
          exp_level[c] = !exp_level[c];
          pulse_total[c]++;
        end
      end
      h2[c] = h1[c];
      h1[c] = raw[c];
    end
  endtask

  task automatic compare_outputs(input string where);
    check({where, ".enable"}, enable, exp_level[0]);
    check({where, ".up_down"}, up_down, exp_level[1]);
    check({where, ".run_pulse"}, run_pulse, exp_pulse[0]);
    check({where, ".dir_pulse"}, dir_pulse, exp_pulse[1]);
  endtask

  // Logical press values; the pins are inverted for the active-low build.
  task automatic drive(input bit r, input bit d);
`ifdef BTN_ACTIVE_LOW_EN
    btn_run = ~r;
    btn_dir = ~d;
`else
    btn_run = r;
    btn_dir = d;
`endif
  endtask

  // Called just after a falling edge; returns just after the next falling edge.
  task automatic tick(input bit r, input bit d, input string where);
    drive(r, d);
    @(posedge clk);
    model_edge(r, d);
    @(negedge clk);
    compare_outputs(where);
  endtask

  task automatic ticks(input bit r, input bit d, input int n, input string where);
    for (int i = 0; i < n; i++) tick(r, d, where);
  endtask

  task automatic do_reset(input string where);
    #2 rst = 1'b1;
    #1;
    model_reset();
    compare_outputs({where, ".in_rst"});
    repeat (3) @(posedge clk);
    @(negedge clk);
    compare_outputs({where, ".hold_rst"});
    rst = 1'b0;
  endtask

  task automatic report(input string name);
    $display("scenario %-14s run_pulses=%0d dir_pulses=%0d enable=%0b up_down=%0b miscompares=%0d",
             name, pulse_total[0], pulse_total[1], enable, up_down, err_count);
  endtask

  initial begin
    int hold [2];
    bit lvl [2];
    int p0;
    pulse_total[0] = 0;
    pulse_total[1] = 0;
    drive(1'b0, 1'b0);
    @(negedge clk);
    do_reset("reset");
    ticks(1'b0, 1'b0, 5, "idle");
    report("reset");

    p0 = pulse_total[0];
    ticks(1'b1, 1'b0, 20, "press");
    ticks(1'b0, 1'b0, 10, "press_rel");
    check("press.count", enable, 1'b1);
    vec_count++;
    if (pulse_total[0] - p0 != 1) begin
      err_count++;
      $display("FAIL press.model_count got=%0d expected=1", pulse_total[0] - p0);
    end
    report("clean_press");

    for (int i = 0; i < 8; i++) ticks(i % 2 == 0, 1'b0, 0, "nop");
    for (int i = 0; i < 8; i++) ticks(1'b0, (i % 2) == 0, 2, "bounce");
    ticks(1'b0, 1'b0, 10, "bounce_idle");
    check("bounce.up_down", up_down, 1'b1);
    report("bounce");

    ticks(1'b1, 1'b0, 10, "rb_press");
    ticks(1'b0, 1'b0, 2, "rb_rel");
    ticks(1'b1, 1'b0, 1, "rb_glitch");
    ticks(1'b0, 1'b0, 10, "rb_rel2");
    ticks(1'b1, 1'b0, 10, "rb_press2");
    ticks(1'b0, 1'b0, 10, "rb_idle");
    report("release_bounce");

    ticks(1'b1, 1'b1, 10, "simul");
    ticks(1'b0, 1'b0, 10, "simul_rel");
    report("simultaneous");

    ticks(1'b1, 1'b0, 2, "mid_rise");
    do_reset("mid_rst");
    ticks(1'b1, 1'b0, 12, "mid_hold");
    ticks(1'b0, 1'b0, 10, "mid_rel");
    report("reset_mid");

    hold[0] = 1; hold[1] = 1;
    lvl[0] = 1'b0; lvl[1] = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      for (int c = 0; c < 2; c++) begin
        hold[c]--;
        if (hold[c] == 0) begin
          lvl[c] = !lvl[c];
          hold[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(6, 14) : $urandom_range(1, 5);
        end
      end
      tick(lvl[0], lvl[1], "rand");
      if (i == 700) do_reset("rand_rst");
    end
    ticks(1'b0, 1'b0, 12, "rand_idle");
    report("random");

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

endmodule
